// File: rtl/nios_dct_trace_ctrl_if.sv
// DCT word handshake between the trace capture sequencer and the trace sink.
// A word transfers on the cycle where dct_valid and dct_ready are both high.
interface nios_dct_trace_ctrl_if #(
   parameter int BUF_W = 30,
   parameter int CNT_W = 4
);
   logic             dct_valid;
   logic             dct_ready;
   logic [BUF_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;

   modport master (
      output dct_valid,
      output dct_buffer,
      output dct_count,
      input  dct_ready
   );

   modport slave (
      input  dct_valid,
      input  dct_buffer,
      input  dct_count,
      output dct_ready
   );
endinterface

// File: rtl/nios_dct_trace_ctrl.sv
// Packs 2-bit trace fragments into 30-bit DCT words and sequences test_ending/test_has_ended.
// Latency: a word is presented on dct_* one cycle after it completes or is flushed.
// Backpressure: the full accumulator waits for dct_ready; fragments arriving meanwhile are dropped and counted.
module nios_dct_trace_ctrl #(
   parameter int FRAG_W = 2,
   parameter int SLOTS  = 15,
   parameter int CNT_W  = 4,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_en,
   input  logic              frag_valid,
   input  logic [FRAG_W-1:0] frag_data,
   input  logic              flush_req,
   input  logic              end_req,
   nios_dct_trace_ctrl_if.master dct,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count,
   output logic              test_ending,
   output logic              test_has_ended
);
   localparam int BUF_W = FRAG_W * SLOTS;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, ENDED} state_t;

   state_t           state, state_nxt;
   logic [BUF_W-1:0] acc, acc_nxt, ins_acc;
   logic [CNT_W-1:0] acc_cnt, acc_cnt_nxt, ins_cnt;
   logic             flush_pend, flush_pend_nxt;
   logic             load, drop, slot_free;
   logic [BUF_W-1:0] load_buf;
   logic [CNT_W-1:0] load_cnt;
   logic             dct_valid_q;
   logic [BUF_W-1:0] dct_buffer_q;
   logic [CNT_W-1:0] dct_count_q;

   assign slot_free      = !dct_valid_q || dct.dct_ready;
   assign dct.dct_valid  = dct_valid_q;
   assign dct.dct_buffer = dct_buffer_q;
   assign dct.dct_count  = dct_count_q;
   assign test_ending    = (state == FLUSH);
   assign test_has_ended = (state == ENDED);

   always_comb begin
      state_nxt      = state;
      acc_nxt        = acc;
      acc_cnt_nxt    = acc_cnt;
      flush_pend_nxt = flush_pend;
      load           = 1'b0;
      load_buf       = acc;
      load_cnt       = acc_cnt;
      drop           = 1'b0;
      ins_acc        = acc;
      ins_cnt        = acc_cnt;

      // accumulator as it would look with this cycle's fragment appended
      if (frag_valid && acc_cnt != FULL) begin
         for (int i = 0; i < SLOTS; i++) begin
            if (i == int'(acc_cnt)) ins_acc[i*FRAG_W +: FRAG_W] = frag_data;
         end
         ins_cnt = acc_cnt + CNT_W'(1);
      end

      case (state)
         IDLE: begin
            if (end_req)       state_nxt = FLUSH;
            else if (trace_en) state_nxt = RUN;
         end
         RUN: begin
            if (end_req)        state_nxt = FLUSH;
            else if (!trace_en) state_nxt = IDLE;
            if (acc_cnt == FULL) begin
               if (slot_free) begin
                  load           = 1'b1;
                  acc_nxt        = '0;
                  acc_cnt_nxt    = '0;
                  flush_pend_nxt = 1'b0;
                  if (frag_valid) begin
                     acc_nxt[FRAG_W-1:0] = frag_data;
                     acc_cnt_nxt         = CNT_W'(1);
                  end
               end else begin
                  drop = frag_valid;
               end
            end else begin
               acc_nxt     = ins_acc;
               acc_cnt_nxt = ins_cnt;
               if (ins_cnt == FULL || ((flush_req && acc_cnt != '0) || flush_pend)) begin
                  if (slot_free) begin
                     load           = 1'b1;
                     load_buf       = ins_acc;
                     load_cnt       = ins_cnt;
                     acc_nxt        = '0;
                     acc_cnt_nxt    = '0;
                     flush_pend_nxt = 1'b0;
                  end else begin
                     flush_pend_nxt = flush_pend || (flush_req && acc_cnt != '0);
                  end
               end
            end
         end
         FLUSH: begin
            flush_pend_nxt = 1'b0;
            if (slot_free) begin
               if (acc_cnt != '0) begin
                  load        = 1'b1;
                  acc_nxt     = '0;
                  acc_cnt_nxt = '0;
               end else begin
                  state_nxt = ENDED;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         acc          <= '0;
         acc_cnt      <= '0;
         flush_pend   <= 1'b0;
         dct_valid_q  <= 1'b0;
         dct_buffer_q <= '0;
         dct_count_q  <= '0;
         overflow     <= 1'b0;
         drop_count   <= '0;
      end else begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         acc_cnt    <= acc_cnt_nxt;
         flush_pend <= flush_pend_nxt;
         if (load) begin
            dct_valid_q  <= 1'b1;
            dct_buffer_q <= load_buf;
            dct_count_q  <= load_cnt;
         end else if (dct.dct_ready) begin
            dct_valid_q <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end
endmodule
